// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution control: comparator forwarding selects, load/ALU
// hazard stalls, PC-source/flush decision and saturating debug counters.
module branch_resolve_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Branch_ID,
    input  logic             Taken_ID,
    input  logic             Uses_rt_ID,
    input  logic [REG_W-1:0] Rs_ID,
    input  logic [REG_W-1:0] Rt_ID,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] ID_EX_Rd,
    input  logic             EX_MEM_RegWrite,
    input  logic             EX_MEM_MemRead,
    input  logic [REG_W-1:0] EX_MEM_Rd,
    input  logic             MEM_WB_RegWrite,
    input  logic [REG_W-1:0] MEM_WB_Rd,
    output logic             Stall,
    output logic             Bubble_ID_EX,
    output logic             PCSrc,
    output logic             Flush_IF_ID,
    output logic [1:0]       FwdA,
    output logic [1:0]       FwdB,
    output logic [CNT_W-1:0] Branch_cnt,
    output logic [CNT_W-1:0] Taken_cnt,
    output logic [CNT_W-1:0] Stall_cnt
);

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    localparam logic [1:0]       FWD_RF    = 2'b00;
    localparam logic [1:0]       FWD_EXMEM = 2'b01;
    localparam logic [1:0]       FWD_MEMWB = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t     state, state_next;
    logic [1:0] stall_left, stall_left_next;

    logic stall_c, bubble_c, pcsrc_c, flush_c;
    logic resolve, taken_inc, stall_inc;
    logic id_ex_hit, ex_mem_hit;
    logic hazard_load, hazard_alu;
    logic [1:0] fwd_a_c, fwd_b_c;

    // Register $0 is hard-wired, so a producer writing it never matches.
    function automatic logic reg_match(input logic we, input logic [REG_W-1:0] rd,
                                       input logic [REG_W-1:0] src);
        return we && (rd != '0) && (rd == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        if (reg_match(EX_MEM_RegWrite, EX_MEM_Rd, src) && !EX_MEM_MemRead)
            return FWD_EXMEM;
        else if (reg_match(MEM_WB_RegWrite, MEM_WB_Rd, src))
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        id_ex_hit   = reg_match(ID_EX_RegWrite, ID_EX_Rd, Rs_ID) ||
                      (Uses_rt_ID && reg_match(ID_EX_RegWrite, ID_EX_Rd, Rt_ID));
        ex_mem_hit  = reg_match(EX_MEM_RegWrite, EX_MEM_Rd, Rs_ID) ||
                      (Uses_rt_ID && reg_match(EX_MEM_RegWrite, EX_MEM_Rd, Rt_ID));
        hazard_load = id_ex_hit && ID_EX_MemRead;
        hazard_alu  = (id_ex_hit && !ID_EX_MemRead) || (ex_mem_hit && EX_MEM_MemRead);
        fwd_a_c     = Branch_ID ? fwd_sel(Rs_ID) : FWD_RF;
        fwd_b_c     = (Branch_ID && Uses_rt_ID) ? fwd_sel(Rt_ID) : FWD_RF;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            stall_left <= 2'd0;
        end else begin
            state      <= state_next;
            stall_left <= stall_left_next;
        end
    end

    // The detect cycle is itself the first stall cycle, so stall_left holds the
    // stall cycles still owed after the current one has been spent.
    always_comb begin
        state_next      = state;
        stall_left_next = stall_left;
        stall_c         = 1'b0;
        bubble_c        = 1'b0;
        pcsrc_c         = 1'b0;
        flush_c         = 1'b0;
        resolve         = 1'b0;
        case (state)
            IDLE: begin
                if (Branch_ID) begin
                    if (hazard_load) begin
                        stall_c         = 1'b1;
                        bubble_c        = 1'b1;
                        stall_left_next = 2'd2 - 2'd1;
                        state_next      = STALL;
                    end else if (hazard_alu) begin
                        stall_c         = 1'b1;
                        bubble_c        = 1'b1;
                        stall_left_next = 2'd1 - 2'd1;
                    end else begin
                        resolve = 1'b1;
                        pcsrc_c = Taken_ID;
                        flush_c = Taken_ID;
                    end
                end
            end
            STALL: begin
                stall_c         = 1'b1;
                bubble_c        = 1'b1;
                stall_left_next = stall_left - 2'd1;
                if (stall_left <= 2'd1) begin
                    stall_left_next = 2'd0;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next      = IDLE;
                stall_left_next = 2'd0;
            end
        endcase
    end

    assign taken_inc = resolve && Taken_ID;
    assign stall_inc = stall_c;

    // Outputs are forced low while reset is held, even with a branch in ID.
    assign Stall        = stall_c  && Rst_n;
    assign Bubble_ID_EX = bubble_c && Rst_n;
    assign PCSrc        = pcsrc_c  && Rst_n;
    assign Flush_IF_ID  = flush_c  && Rst_n;
    assign FwdA         = Rst_n ? fwd_a_c : FWD_RF;
    assign FwdB         = Rst_n ? fwd_b_c : FWD_RF;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Branch_cnt <= '0;
            Taken_cnt  <= '0;
            Stall_cnt  <= '0;
        end else begin
            if (resolve && (Branch_cnt != CNT_MAX))
                Branch_cnt <= Branch_cnt + CNT_ONE;
            if (taken_inc && (Taken_cnt != CNT_MAX))
                Taken_cnt <= Taken_cnt + CNT_ONE;
            if (stall_inc && (Stall_cnt != CNT_MAX))
                Stall_cnt <= Stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_resolve_ctrl;

    logic        Clk;
    logic        Rst_n;
    logic        Branch_ID, Taken_ID, Uses_rt_ID;
    logic [4:0]  Rs_ID, Rt_ID;
    logic        ID_EX_RegWrite, ID_EX_MemRead;
    logic [4:0]  ID_EX_Rd;
    logic        EX_MEM_RegWrite, EX_MEM_MemRead;
    logic [4:0]  EX_MEM_Rd;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_Rd;
    logic        Stall, Bubble_ID_EX, PCSrc, Flush_IF_ID;
    logic [1:0]  FwdA, FwdB;
    logic [15:0] Branch_cnt, Taken_cnt, Stall_cnt;

    branch_resolve_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Branch_ID(Branch_ID), .Taken_ID(Taken_ID), .Uses_rt_ID(Uses_rt_ID),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_Rd(EX_MEM_Rd),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_Rd(MEM_WB_Rd),
        .Stall(Stall), .Bubble_ID_EX(Bubble_ID_EX), .PCSrc(PCSrc), .Flush_IF_ID(Flush_IF_ID),
        .FwdA(FwdA), .FwdB(FwdB),
        .Branch_cnt(Branch_cnt), .Taken_cnt(Taken_cnt), .Stall_cnt(Stall_cnt)
    );

    typedef struct {
        int          cyc;
        logic [7:0]  ctrl;
        logic [15:0] bc, tc, sc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [15:0] m_bc = 0, m_tc = 0, m_sc = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: every expectation is tagged with the cycle it belongs to.
    always @(negedge Clk) begin
        exp_t e;
        logic [7:0] act;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("[TB] FAIL %s: expectation for cycle %0d never checked (now %0d)", e.name, e.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e   = sb.pop_front();
            act = {Stall, Bubble_ID_EX, PCSrc, Flush_IF_ID, FwdA, FwdB};
            total++;
            if (act !== e.ctrl) begin
                bad++;
                $display("[TB] FAIL %s ctrl {stall,bubble,pcsrc,flush,fwda,fwdb}: got %b want %b", e.name, act, e.ctrl);
            end
            total++;
            if (Branch_cnt !== e.bc) begin
                bad++;
                $display("[TB] FAIL %s Branch_cnt: got %0d want %0d", e.name, Branch_cnt, e.bc);
            end
            total++;
            if (Taken_cnt !== e.tc) begin
                bad++;
                $display("[TB] FAIL %s Taken_cnt: got %0d want %0d", e.name, Taken_cnt, e.tc);
            end
            total++;
            if (Stall_cnt !== e.sc) begin
                bad++;
                $display("[TB] FAIL %s Stall_cnt: got %0d want %0d", e.name, Stall_cnt, e.sc);
            end
        end
    end

    task automatic drive(input logic br, tk, urt, input logic [4:0] rs, rt,
                         input logic ixw, ixm, input logic [4:0] ixd,
                         input logic emw, emm, input logic [4:0] emd,
                         input logic mww, input logic [4:0] mwd);
        @(posedge Clk);
        #1;
        Branch_ID       = br;  Taken_ID       = tk;  Uses_rt_ID = urt;
        Rs_ID           = rs;  Rt_ID          = rt;
        ID_EX_RegWrite  = ixw; ID_EX_MemRead  = ixm; ID_EX_Rd   = ixd;
        EX_MEM_RegWrite = emw; EX_MEM_MemRead = emm; EX_MEM_Rd  = emd;
        MEM_WB_RegWrite = mww; MEM_WB_Rd      = mwd;
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Counter expectations are the running totals from earlier cycles; this
    // cycle's resolve/stall only shows up after the next clock edge.
    task automatic applyStimulus(input string nm, input logic es, eb, ep, ef,
                                 input logic [1:0] efa, efb, input bit chk);
        exp_t e;
        if (!Rst_n) begin
            m_bc = 0; m_tc = 0; m_sc = 0;
        end
        if (chk) begin
            e.cyc  = cyc;
            e.ctrl = {es, eb, ep, ef, efa, efb};
            e.bc   = m_bc;
            e.tc   = m_tc;
            e.sc   = m_sc;
            e.name = nm;
            sb.push_back(e);
        end
        if (Rst_n) begin
            if (Branch_ID && !es) begin
                m_bc = sat_inc(m_bc);
                if (ep) m_tc = sat_inc(m_tc);
            end
            if (es) m_sc = sat_inc(m_sc);
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        drive(0,0,0,0,0, 0,0,0, 0,0,0, 0,0);
        applyStimulus("reset", 0,0,0,0, 2'b00,2'b00, 1);
        drive(0,0,0,0,0, 0,0,0, 0,0,0, 0,0);
        Rst_n = 1'b1;
        applyStimulus("idle", 0,0,0,0, 2'b00,2'b00, 1);

        drive(1,1,1,3,4, 0,0,0, 0,0,0, 0,0);
        applyStimulus("taken_no_hazard", 0,0,1,1, 2'b00,2'b00, 1);

        drive(1,0,1,3,4, 1,1,3, 0,0,0, 0,0);
        applyStimulus("load_ahead_c1", 1,1,0,0, 2'b00,2'b00, 1);
        drive(1,0,1,3,4, 0,0,0, 1,1,3, 0,0);
        applyStimulus("load_ahead_c2", 1,1,0,0, 2'b00,2'b00, 1);
        drive(1,0,1,3,4, 0,0,0, 0,0,0, 1,3);
        applyStimulus("load_ahead_resolve", 0,0,0,0, 2'b10,2'b00, 1);

        drive(1,1,1,1,4, 1,0,4, 0,0,0, 0,0);
        applyStimulus("alu_ahead_stall", 1,1,0,0, 2'b00,2'b00, 1);
        drive(1,1,1,1,4, 0,0,0, 1,0,4, 0,0);
        applyStimulus("alu_ahead_resolve", 0,0,1,1, 2'b00,2'b01, 1);

        drive(1,0,1,5,6, 0,0,0, 1,0,5, 1,5);
        applyStimulus("exmem_over_memwb", 0,0,0,0, 2'b01,2'b00, 1);

        drive(1,1,1,0,0, 1,1,0, 1,0,0, 1,0);
        applyStimulus("reg0_never_match", 0,0,1,1, 2'b00,2'b00, 1);

        drive(1,0,0,2,7, 1,1,7, 0,0,0, 1,7);
        applyStimulus("single_operand_rt_ignored", 0,0,0,0, 2'b00,2'b00, 1);

        drive(1,1,0,8,0, 0,0,0, 1,1,8, 0,0);
        applyStimulus("load_one_stage_ahead", 1,1,0,0, 2'b00,2'b00, 1);
        drive(1,1,0,8,0, 0,0,0, 0,0,0, 1,8);
        applyStimulus("load_one_ahead_resolve", 0,0,1,1, 2'b10,2'b00, 1);

        drive(1,0,1,9,10, 0,0,0, 0,0,9, 1,9);
        applyStimulus("exmem_no_regwrite", 0,0,0,0, 2'b10,2'b00, 1);

        drive(1,1,1,3,3, 1,1,3, 0,0,0, 0,0);
        applyStimulus("rst_stall_c1", 1,1,0,0, 2'b00,2'b00, 1);
        drive(1,1,1,3,3, 0,0,0, 1,1,3, 0,0);
        Rst_n = 1'b0;
        applyStimulus("rst_mid_stall", 0,0,0,0, 2'b00,2'b00, 1);
        drive(0,0,0,0,0, 0,0,0, 0,0,0, 0,0);
        Rst_n = 1'b1;
        applyStimulus("after_reset", 0,0,0,0, 2'b00,2'b00, 1);
        drive(1,1,1,3,4, 0,0,0, 0,0,0, 0,0);
        applyStimulus("idle_after_reset", 0,0,1,1, 2'b00,2'b00, 1);

        for (int i = 0; i < 65535; i++) begin
            drive(1,0,0,1,2, 0,0,0, 0,0,0, 0,0);
            applyStimulus("fill", 0,0,0,0, 2'b00,2'b00, 0);
        end
        drive(1,0,0,1,2, 0,0,0, 0,0,0, 0,0);
        applyStimulus("branch_cnt_saturated", 0,0,0,0, 2'b00,2'b00, 1);
        drive(0,0,0,0,0, 0,0,0, 0,0,0, 0,0);
        applyStimulus("branch_cnt_held", 0,0,0,0, 2'b00,2'b00, 1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge Clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
